// File: rtl/in_ep_tx_sequencer.sv
// Read-side sequencer for one IN endpoint: streams a packet from the transactional FIFO to the
// transmitter, then commits or rolls back the FIFO read on the host handshake; owns DATA0/DATA1.
module in_ep_tx_sequencer #(
    parameter int unsigned DATA_WID   = 8,
    parameter int unsigned MAX_PKT    = 64,
    parameter int unsigned HS_TIMEOUT = 816
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                inToken_i,
    input  logic                toggleReset_i,
    output logic                nak_o,
    output logic                busy_o,
    output logic                dataToggle_o,
    output logic                popTransDone_o,
    output logic                popTransSuccess_o,
    output logic                popData_o,
    input  logic                dataAvailable_i,
    input  logic                isLast_i,
    input  logic [DATA_WID-1:0] data_i,
    output logic                txReqSend_o,
    output logic                txPidData1_o,
    input  logic                txReqAck_i,
    output logic                txDataValid_o,
    input  logic                txReady_i,
    output logic [DATA_WID-1:0] txData_o,
    output logic                txIsLast_o,
    input  logic                txDone_i,
    input  logic                ackReceived_i,
    input  logic                hsError_i
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT + 1);
    localparam int unsigned TMR_W = $clog2(HS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT_TXDONE,
        S_WAIT_HS,
        S_COMMIT,
        S_ROLLBACK
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               toggle_q, toggle_d;
    logic               nak_q, nak_d;

    logic               stream_last_c;
    logic               tx_hs_c;

    // Packet ends on the FIFO's last committed byte or when the payload limit is reached
    assign stream_last_c = isLast_i | (byte_cnt_q == CNT_W'(MAX_PKT - 1));
    assign tx_hs_c       = (state_q == S_STREAM) & dataAvailable_i & txReady_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            toggle_q   <= 1'b0;
            nak_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            timer_q    <= timer_d;
            toggle_q   <= toggle_d;
            nak_q      <= nak_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        timer_d    = timer_q;
        toggle_d   = toggle_q;
        nak_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inToken_i) begin
                    if (dataAvailable_i) state_d = S_START;
                    else                 nak_d   = 1'b1;
                end
            end
            S_START: begin
                if (txReqAck_i) begin
                    state_d    = S_STREAM;
                    byte_cnt_d = '0;
                end
            end
            S_STREAM: begin
                if (tx_hs_c) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (stream_last_c) state_d = S_WAIT_TXDONE;
                end
            end
            S_WAIT_TXDONE: begin
                if (txDone_i) begin
                    state_d = S_WAIT_HS;
                    timer_d = '0;
                end
            end
            S_WAIT_HS: begin
                timer_d = timer_q + TMR_W'(1);
                // ACK takes priority over a simultaneous error or timeout
                if (ackReceived_i) begin
                    state_d = S_COMMIT;
                end else if (hsError_i || (timer_q == TMR_W'(HS_TIMEOUT - 1))) begin
                    state_d = S_ROLLBACK;
                end
            end
            S_COMMIT: begin
                toggle_d = ~toggle_q;
                state_d  = S_IDLE;
            end
            S_ROLLBACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (toggleReset_i) toggle_d = 1'b0;
    end

    // Outputs decoded from state; while in reset only the rollback request is driven
    always_comb begin
        nak_o             = 1'b0;
        busy_o            = 1'b0;
        dataToggle_o      = 1'b0;
        popTransDone_o    = 1'b0;
        popTransSuccess_o = 1'b0;
        popData_o         = 1'b0;
        txReqSend_o       = 1'b0;
        txPidData1_o      = 1'b0;
        txDataValid_o     = 1'b0;
        txData_o          = '0;
        txIsLast_o        = 1'b0;
        if (!rstn_i) begin
            popTransDone_o = 1'b1;
        end else begin
            nak_o        = nak_q;
            busy_o       = (state_q != S_IDLE);
            dataToggle_o = toggle_q;
            txPidData1_o = toggle_q;
            txData_o     = data_i;
            case (state_q)
                S_START: begin
                    txReqSend_o = 1'b1;
                end
                S_STREAM: begin
                    txDataValid_o = dataAvailable_i;
                    txIsLast_o    = stream_last_c;
                    popData_o     = tx_hs_c;
                end
                S_COMMIT: begin
                    popTransDone_o    = 1'b1;
                    popTransSuccess_o = 1'b1;
                end
                S_ROLLBACK: begin
                    popTransDone_o = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_ep_tx_sequencer.sv
// Scoreboard bench for in_ep_tx_sequencer: a transactional FIFO model and an accepting transmitter
// surround the DUT; directed tokens push expected bytes/outcomes that a negedge monitor checks.
module tb_in_ep_tx_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned MP = 64;
    localparam int unsigned HT = 816;

    typedef struct packed {
        logic          pid;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          inToken_i = 1'b0;
    logic          toggleReset_i = 1'b0;
    logic          nak_o, busy_o, dataToggle_o;
    logic          popTransDone_o, popTransSuccess_o, popData_o;
    logic          dataAvailable_i, isLast_i;
    logic [DW-1:0] data_i;
    logic          txReqSend_o, txPidData1_o, txReqAck_i;
    logic          txDataValid_o, txReady_i, txIsLast_o;
    logic [DW-1:0] txData_o;
    logic          txDone_i = 1'b0;
    logic          ackReceived_i = 1'b0;
    logic          hsError_i = 1'b0;

    int total = 0;
    int bad = 0;

    exp_t exp_q[$];
    bit   done_q[$];
    int   last_cnt = 0, pop_cnt = 0, done_cnt = 0, nak_cnt = 0, req_cnt = 0;

    logic [DW-1:0] mem [0:255];
    int wr = 0, rd = 0, rd_c = 0;
    int rdy_cnt = 0;

    always #5 clk_i = ~clk_i;

    in_ep_tx_sequencer #(.DATA_WID(DW), .MAX_PKT(MP), .HS_TIMEOUT(HT)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .inToken_i(inToken_i), .toggleReset_i(toggleReset_i),
        .nak_o(nak_o), .busy_o(busy_o), .dataToggle_o(dataToggle_o),
        .popTransDone_o(popTransDone_o), .popTransSuccess_o(popTransSuccess_o), .popData_o(popData_o),
        .dataAvailable_i(dataAvailable_i), .isLast_i(isLast_i), .data_i(data_i),
        .txReqSend_o(txReqSend_o), .txPidData1_o(txPidData1_o), .txReqAck_i(txReqAck_i),
        .txDataValid_o(txDataValid_o), .txReady_i(txReady_i), .txData_o(txData_o),
        .txIsLast_o(txIsLast_o), .txDone_i(txDone_i), .ackReceived_i(ackReceived_i),
        .hsError_i(hsError_i)
    );

    // Transactional FIFO model: pops advance rd, commit saves it, rollback restores it
    assign dataAvailable_i = (rd != wr);
    assign isLast_i        = (rd == wr - 1);
    assign data_i          = mem[rd[7:0]];
    always @(posedge clk_i) begin
        if (popTransDone_o) begin
            if (popTransSuccess_o) rd_c <= rd;
            else                   rd   <= rd_c;
        end else if (popData_o) begin
            rd <= rd + 1;
        end
    end

    // Transmitter: accepts start at once, stalls one cycle in four
    assign txReqAck_i = txReqSend_o;
    assign txReady_i  = (rdy_cnt != 2);
    always @(posedge clk_i) rdy_cnt <= (rdy_cnt + 1) % 4;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk_i) begin
        if (rstn_i) begin
            check("pop_equals_handshake", 32'(popData_o), 32'(txDataValid_o & txReady_i));
            if (txDataValid_o && txReady_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%0h with no byte expected", txData_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tx_byte{pid,last,data}", 32'({txPidData1_o, txIsLast_o, txData_o}), 32'(e));
                end
                if (txIsLast_o) last_cnt++;
            end
            if (popData_o) begin
                pop_cnt++;
                check("pop_without_done", 32'(popTransDone_o), 32'd0);
            end
            if (popTransDone_o) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_trans_done: got success=%0b with none expected", popTransSuccess_o);
                end else begin
                    check("trans_success", 32'(popTransSuccess_o), 32'(done_q.pop_front()));
                end
            end
            if (nak_o) nak_cnt++;
            if (txReqSend_o) req_cnt++;
        end
    end

    task automatic fifo_push(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr[7:0]] = DW'(first + i);
            wr++;
        end
    endtask

    task automatic push_pkt(input logic [DW-1:0] first, input int n, input bit pid, input bit success);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pid  = pid;
            e.last = (i == n - 1);
            e.data = DW'(first + i);
            exp_q.push_back(e);
        end
        done_q.push_back(success);
    endtask

    task automatic pulse_toggle_reset();
        @(posedge clk_i); #1 toggleReset_i = 1'b1;
        @(posedge clk_i); #1 toggleReset_i = 1'b0;
    endtask

    // kind: 0 ack, 1 error, 2 timeout, 3 ack+error together, 4 ack with toggle reset during commit
    task automatic run_token(input int kind);
        int base_last;
        int n;
        base_last = last_cnt;
        @(posedge clk_i); #1 inToken_i = 1'b1;
        @(posedge clk_i); #1 inToken_i = 1'b0;
        n = 0;
        while (last_cnt == base_last && n < 2000) begin
            @(posedge clk_i);
            n++;
        end
        if (last_cnt == base_last) begin
            total++;
            bad++;
            $display("FAIL stream_wait: got no last byte within %0d cycles", n);
        end
        #1 txDone_i = 1'b1;
        @(posedge clk_i); #1 txDone_i = 1'b0;
        case (kind)
            0, 4: begin
                ackReceived_i = 1'b1;
                @(posedge clk_i); #1 ackReceived_i = 1'b0;
                if (kind == 4) begin
                    toggleReset_i = 1'b1;
                    @(posedge clk_i); #1 toggleReset_i = 1'b0;
                end
            end
            1: begin
                hsError_i = 1'b1;
                @(posedge clk_i); #1 hsError_i = 1'b0;
            end
            2: begin
                n = 0;
                do begin
                    @(posedge clk_i);
                    n++;
                    @(negedge clk_i);
                end while (!popTransDone_o && n < int'(HT) + 50);
                check("hs_timeout_cycles", 32'(n), 32'(HT));
            end
            default: begin
                ackReceived_i = 1'b1;
                hsError_i     = 1'b1;
                @(posedge clk_i); #1;
                ackReceived_i = 1'b0;
                hsError_i     = 1'b0;
            end
        endcase
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (busy_o && n < 20);
        check("back_to_idle", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n0, r0, p0, d0, n;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_trans_done", 32'(popTransDone_o), 32'd1);
        check("rst_trans_success", 32'(popTransSuccess_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req", 32'(txReqSend_o), 32'd0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check("init_toggle", 32'(dataToggle_o), 32'd0);

        // 1) three bytes, ACK
        fifo_push(8'hA1, 3);
        push_pkt(8'hA1, 3, 1'b0, 1'b1);
        run_token(0);
        check("t1_toggle", 32'(dataToggle_o), 32'd1);
        check("t1_fifo_empty", 32'(dataAvailable_i), 32'd0);

        // 2) error rolls back, retransmit same bytes with same PID
        pulse_toggle_reset();
        #1 check("t2_toggle_reset", 32'(dataToggle_o), 32'd0);
        fifo_push(8'hA1, 3);
        push_pkt(8'hA1, 3, 1'b0, 1'b0);
        run_token(1);
        check("t2_toggle_after_err", 32'(dataToggle_o), 32'd0);
        push_pkt(8'hA1, 3, 1'b0, 1'b1);
        run_token(0);
        check("t2_toggle", 32'(dataToggle_o), 32'd1);

        // 3) 70 bytes split into 64 + 6
        pulse_toggle_reset();
        fifo_push(8'h00, 70);
        push_pkt(8'h00, 64, 1'b0, 1'b1);
        run_token(0);
        check("t3_toggle_mid", 32'(dataToggle_o), 32'd1);
        push_pkt(8'h40, 6, 1'b1, 1'b1);
        run_token(0);
        check("t3_toggle", 32'(dataToggle_o), 32'd0);
        check("t3_fifo_committed", 32'(rd_c), 32'(wr));

        // 4) empty FIFO -> single NAK pulse, nothing else
        n0 = nak_cnt; r0 = req_cnt; p0 = pop_cnt; d0 = done_cnt;
        @(posedge clk_i); #1 inToken_i = 1'b1;
        @(posedge clk_i); #1 inToken_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("t4_nak_pulses", 32'(nak_cnt - n0), 32'd1);
        check("t4_no_req", 32'(req_cnt - r0), 32'd0);
        check("t4_no_pop", 32'(pop_cnt - p0), 32'd0);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check("t4_idle", 32'(busy_o), 32'd0);

        // 5) handshake timeout, then ACK+error together commits
        fifo_push(8'h55, 2);
        push_pkt(8'h55, 2, 1'b0, 1'b0);
        run_token(2);
        check("t5_toggle_after_timeout", 32'(dataToggle_o), 32'd0);
        push_pkt(8'h55, 2, 1'b0, 1'b1);
        run_token(3);
        check("t5_toggle", 32'(dataToggle_o), 32'd1);

        // 6) reset mid-stream after two pops
        fifo_push(8'hC1, 4);
        push_pkt(8'hC1, 4, 1'b1, 1'b1);
        p0 = pop_cnt;
        @(posedge clk_i); #1 inToken_i = 1'b1;
        @(posedge clk_i); #1 inToken_i = 1'b0;
        n = 0;
        while (pop_cnt < p0 + 2 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        check("t6_two_pops", 32'(pop_cnt - p0), 32'd2);
        #1 rstn_i = 1'b0;
        #1;
        check("t6_rst_done", 32'(popTransDone_o), 32'd1);
        check("t6_rst_success", 32'(popTransSuccess_o), 32'd0);
        check("t6_rst_no_pop", 32'(popData_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.delete();
        done_q.delete();
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check("t6_toggle", 32'(dataToggle_o), 32'd0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_rd_restored", 32'(rd), 32'(wr - 4));
        push_pkt(8'hC1, 4, 1'b0, 1'b1);
        run_token(4);
        check("t6_toggle_reset_wins", 32'(dataToggle_o), 32'd0);
        check("t6_fifo_committed", 32'(rd_c), 32'(wr));

        repeat (3) @(negedge clk_i);
        check("exp_bytes_drained", 32'(exp_q.size()), 32'd0);
        check("exp_done_drained", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
